// File: rtl/polybius_stream_ctrl_if.sv
// Byte-stream handshake bundle for polybius_stream_ctrl.
// Signals:
//   mode      - 0 = encrypt, 1 = decrypt (taken with byte 0 of a block)
//   in_valid  - input byte valid
//   in_ready  - controller can accept an input byte
//   in_data   - input byte
//   out_valid - output byte valid
//   out_ready - downstream accepts the output byte
//   out_data  - cipher output byte
//   out_last  - final byte of a block
// Modports: master drives the input side and takes the output side; slave is the controller.
interface polybius_stream_ctrl_if;
    localparam int unsigned DATA_W = 8;

    logic              mode;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output mode, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  mode, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/polybius_stream_ctrl.sv
// Polybius cipher pair plus a serial block controller in front of them.
//
// encryptor / decryptor: combinational keyed Polybius square. The 25-letter
// alphabet (I and J share a cell) is rotated by SEC_LEN cells; a letter at
// cell p encodes as (p/5+1)*10 + (p%5+1). Byte i of a block sits at
// text_in[8*i +: 8]. Non-letters encrypt to 8'h00; invalid codes decrypt to '?'.
//
// polybius_stream_ctrl: collects MSG_LEN bytes, runs them through the cipher
// selected by the block's mode bit, then emits the result byte-by-byte.
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset
//   s        - polybius_stream_ctrl_if.slave (mode, in_*, out_*)
//   busy     - high except when idle in COLLECT with idx==0 (combinational)
//   blk_cnt  - number of fully emitted blocks, wraps
//   err      - sticky input-error flag
// Optional feature: define POLYBIUS_ERR_CHECK_EN to enable input checking on
// err; otherwise err is tied low.

module encryptor #(
    parameter int unsigned MSG_LEN = 7,
    parameter int unsigned SEC_LEN = 7
) (
    input  logic [8*MSG_LEN-1:0] text_in,
    output logic [8*MSG_LEN-1:0] text_out
);
    localparam logic [7:0] SHIFT8 = 8'(SEC_LEN % 25);

    // Letter -> two-digit row/column code of the rotated square.
    function automatic logic [7:0] enc_byte(input logic [7:0] ch);
        logic [7:0] k;
        logic [7:0] pos;
        logic [7:0] code;
        k    = 8'h00;
        pos  = 8'h00;
        code = 8'h00;
        if (ch >= 8'h41 && ch <= 8'h5A) begin
            k = ch - 8'h41;
            // J folds onto I; everything after J moves down one cell
            if (k >= 8'd9) begin
                k = k - 8'd1;
            end
            pos  = (k + SHIFT8) % 8'd25;
            code = (pos / 8'd5 + 8'd1) * 8'd10 + (pos % 8'd5) + 8'd1;
        end
        return code;
    endfunction

    always_comb begin
        text_out = '0;
        for (int unsigned i = 0; i < MSG_LEN; i++) begin
            text_out[8*i +: 8] = enc_byte(text_in[8*i +: 8]);
        end
    end
endmodule

module decryptor #(
    parameter int unsigned MSG_LEN = 7,
    parameter int unsigned SEC_LEN = 7
) (
    input  logic [8*MSG_LEN-1:0] text_in,
    output logic [8*MSG_LEN-1:0] text_out
);
    localparam logic [7:0] SHIFT8 = 8'(SEC_LEN % 25);

    // Row/column code -> letter of the rotated square.
    function automatic logic [7:0] dec_byte(input logic [7:0] code);
        logic [7:0] r;
        logic [7:0] c;
        logic [7:0] pos;
        logic [7:0] k;
        logic [7:0] ch;
        r   = code / 8'd10;
        c   = code % 8'd10;
        pos = 8'h00;
        k   = 8'h00;
        ch  = 8'h3F;
        if (r >= 8'd1 && r <= 8'd5 && c >= 8'd1 && c <= 8'd5) begin
            pos = (r - 8'd1) * 8'd5 + (c - 8'd1);
            k   = (pos + 8'd25 - SHIFT8) % 8'd25;
            // skip over J when mapping back to ASCII
            if (k >= 8'd9) begin
                k = k + 8'd1;
            end
            ch = 8'h41 + k;
        end
        return ch;
    endfunction

    always_comb begin
        text_out = '0;
        for (int unsigned i = 0; i < MSG_LEN; i++) begin
            text_out[8*i +: 8] = dec_byte(text_in[8*i +: 8]);
        end
    end
endmodule

module polybius_stream_ctrl #(
    parameter int unsigned MSG_LEN = 7,
    parameter int unsigned SEC_LEN = 7,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    polybius_stream_ctrl_if.slave s,
    output logic                  busy,
    output logic [CNT_W-1:0]      blk_cnt,
    output logic                  err
);
    localparam int unsigned      IDX_W    = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_LEN - 1);

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_SETTLE,
        ST_EMIT
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d, idx_nxt;
    logic               mode_q, mode_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic [7:0]         out_data_q, out_data_d;
    logic [CNT_W-1:0]   blk_cnt_q, blk_cnt_d;
    logic               in_wr;
    logic               out_ld;

    logic [7:0]         in_buf  [MSG_LEN];
    logic [7:0]         out_buf [MSG_LEN];
    logic [8*MSG_LEN-1:0] cipher_in;
    logic [8*MSG_LEN-1:0] enc_out;
    logic [8*MSG_LEN-1:0] dec_out;
    logic [8*MSG_LEN-1:0] sel_out;

    // Pack the collected block for the cipher pair.
    always_comb begin
        cipher_in = '0;
        for (int unsigned i = 0; i < MSG_LEN; i++) begin
            cipher_in[8*i +: 8] = in_buf[i];
        end
    end

    encryptor #(.MSG_LEN(MSG_LEN), .SEC_LEN(SEC_LEN)) u_enc (
        .text_in  (cipher_in),
        .text_out (enc_out)
    );

    decryptor #(.MSG_LEN(MSG_LEN), .SEC_LEN(SEC_LEN)) u_dec (
        .text_in  (cipher_in),
        .text_out (dec_out)
    );

    assign sel_out = mode_q ? dec_out : enc_out;
    assign idx_nxt = idx_q + IDX_W'(1);

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        blk_cnt_d   = blk_cnt_q;
        in_wr       = 1'b0;
        out_ld      = 1'b0;

        case (state_q)
            ST_COLLECT: begin
                if (s.in_valid) begin
                    in_wr = 1'b1;
                    if (idx_q == '0) begin
                        mode_d = s.mode;
                    end
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = ST_SETTLE;
                    end else begin
                        idx_d = idx_nxt;
                    end
                end
            end

            ST_SETTLE: begin
                // Cipher output is stable now; capture it and present byte 0.
                out_ld      = 1'b1;
                idx_d       = '0;
                out_valid_d = 1'b1;
                out_data_d  = sel_out[7:0];
                out_last_d  = (IDX_LAST == '0);
                state_d     = ST_EMIT;
            end

            ST_EMIT: begin
                if (s.out_ready) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d       = '0;
                        blk_cnt_d   = blk_cnt_q + CNT_W'(1);
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = ST_COLLECT;
                    end else begin
                        idx_d      = idx_nxt;
                        out_data_d = out_buf[idx_nxt];
                        out_last_d = (idx_nxt == IDX_LAST);
                    end
                end
            end

            default: begin
                state_d = ST_COLLECT;
                idx_d   = '0;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_COLLECT;
            idx_q       <= '0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= 8'h00;
            blk_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            blk_cnt_q   <= blk_cnt_d;
        end
    end

    // Block buffers carry no reset; their contents only matter once filled.
    always_ff @(posedge clk) begin
        if (in_wr) begin
            in_buf[idx_q] <= s.in_data;
        end
        if (out_ld) begin
            for (int unsigned i = 0; i < MSG_LEN; i++) begin
                out_buf[i] <= sel_out[8*i +: 8];
            end
        end
    end

`ifdef POLYBIUS_ERR_CHECK_EN
    logic err_q;
    logic byte_mode;

    // Letters 'A'..'Z' for encrypt; both code digits in 1..5 for decrypt.
    function automatic logic byte_ok(input logic m, input logic [7:0] d);
        logic [7:0] r;
        logic [7:0] c;
        r = d / 8'd10;
        c = d % 8'd10;
        if (m) begin
            return (r >= 8'd1 && r <= 8'd5 && c >= 8'd1 && c <= 8'd5);
        end
        return (d >= 8'h41 && d <= 8'h5A);
    endfunction

    // Byte 0 is judged by the mode arriving with it, later bytes by the latched mode.
    assign byte_mode = (idx_q == '0) ? s.mode : mode_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (in_wr && !byte_ok(byte_mode, s.in_data)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign s.in_ready  = (state_q == ST_COLLECT);
    assign s.out_valid = out_valid_q;
    assign s.out_data  = out_data_q;
    assign s.out_last  = out_last_q;
    assign busy        = !((state_q == ST_COLLECT) && (idx_q == '0));
    assign blk_cnt     = blk_cnt_q;
endmodule
